// File: rtl/cadder_sweep_pkg.sv
// Shared types and helpers for the cadder sweep sequencer.
package cadder_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int sweep_cycles(input int width, input int latency);
      return (1 << (2 * width)) * (latency + 1);
   endfunction

   // Sum at one bit wider than the operands so no carry is lost.
   function automatic logic [32:0] exp_sum(input logic [31:0] a,
                                           input logic [31:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/cadder_sweep_opgen.sv
// Operand pair counter: {A,B} index with B as the fast-moving low half.
module cadder_sweep_opgen
   import cadder_sweep_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             last
);

   logic [2*WIDTH-1:0] idx;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         idx <= '0;
      end else if (advance) begin
         idx <= idx + (2*WIDTH)'(1);
      end
   end

   assign {A, B} = idx;
   assign last   = &idx;

endmodule

// File: rtl/cadder_sweep_ctrl.sv
// Exhaustive self-checking sweep of a clocked adder.
// Define CADDER_SWEEP_FIRSTFAIL_EN to add first-mismatch capture ports.
module cadder_sweep_ctrl
   import cadder_sweep_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   input  logic [WIDTH:0]   Z,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [2*WIDTH:0] err_count
`ifdef CADDER_SWEEP_FIRSTFAIL_EN
   ,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [WIDTH:0]   fail_z,
   output logic             fail_valid
`endif
);

   localparam logic [3:0] WLAST = 4'(LATENCY - 1);

   state_t             state;
   logic [3:0]         wcnt;
   logic               clear;
   logic               advance;
   logic               last;
   logic               running;
   logic               mismatch;
   logic [2*WIDTH:0]   err_next;

   assign running  = (state == HOLD) || (state == CHECK);
   assign clear    = ((state == IDLE) && start) || (running && abort);
   assign advance  = (state == CHECK) && !abort;
   assign mismatch = 33'(Z) != exp_sum(32'(A), 32'(B));
   assign err_next = err_count + (2*WIDTH+1)'(mismatch);

   cadder_sweep_opgen #(
      .WIDTH(WIDTH)
   ) u_opgen (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .advance(advance),
      .A      (A),
      .B      (B),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wcnt      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= HOLD;
                  busy      <= 1'b1;
                  wcnt      <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
               end
            end
            HOLD: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  pass  <= 1'b0;
               end else if (wcnt == WLAST) begin
                  state <= CHECK;
                  wcnt  <= '0;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            CHECK: begin
               // An abort discards the compare made in this cycle.
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  pass  <= 1'b0;
               end else begin
                  err_count <= err_next;
                  if (last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == '0);
                  end else begin
                     state <= HOLD;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CADDER_SWEEP_FIRSTFAIL_EN
   always_ff @(posedge clk) begin
      if (rst || ((state == IDLE) && start)) begin
         fail_a     <= '0;
         fail_b     <= '0;
         fail_z     <= '0;
         fail_valid <= 1'b0;
      end else if (advance && mismatch && !fail_valid) begin
         fail_a     <= A;
         fail_b     <= B;
         fail_z     <= Z;
         fail_valid <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cadder_sweep_ctrl.sv
// Bench for cadder_sweep_ctrl: table of sweeps plus abort/hold/reset cases.
module tb_cadder_sweep_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       start1, abort1, busy1, done1, pass1;
   logic [3:0] A1, B1;
   logic [4:0] Z1;
   logic [8:0] err1;
   logic       start3, abort3, busy3, done3, pass3;
   logic [3:0] A3, B3;
   logic [4:0] Z3;
   logic [8:0] err3;
`ifdef CADDER_SWEEP_FIRSTFAIL_EN
   logic [3:0] fa1, fb1, fa3, fb3;
   logic [4:0] fz1, fz3;
   logic       fv1, fv3;
`endif

   cadder_sweep_ctrl #(.WIDTH(4), .LATENCY(1)) u1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1),
      .A(A1), .B(B1), .Z(Z1), .busy(busy1), .done(done1),
      .pass(pass1), .err_count(err1)
`ifdef CADDER_SWEEP_FIRSTFAIL_EN
      , .fail_a(fa1), .fail_b(fb1), .fail_z(fz1), .fail_valid(fv1)
`endif
   );

   cadder_sweep_ctrl #(.WIDTH(4), .LATENCY(3)) u3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3),
      .A(A3), .B(B3), .Z(Z3), .busy(busy3), .done(done3),
      .pass(pass3), .err_count(err3)
`ifdef CADDER_SWEEP_FIRSTFAIL_EN
      , .fail_a(fa3), .fail_b(fb3), .fail_z(fz3), .fail_valid(fv3)
`endif
   );

   // Adder models: pipelined sum with selectable depth and a Z[4] stuck-at-0 fault.
   int         alat1 = 1, alat3 = 3;
   bit         stuck1 = 1'b0, stuck3 = 1'b0;
   logic [4:0] p1 [8];
   logic [4:0] p3 [8];

   always @(posedge clk) begin
      p1[0] <= {1'b0, A1} + {1'b0, B1};
      p3[0] <= {1'b0, A3} + {1'b0, B3};
      for (int i = 1; i < 8; i++) begin
         p1[i] <= p1[i-1];
         p3[i] <= p3[i-1];
      end
   end

   assign Z1 = stuck1 ? (p1[alat1-1] & 5'h0f) : p1[alat1-1];
   assign Z3 = stuck3 ? (p3[alat3-1] & 5'h0f) : p3[alat3-1];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: expected operand pairs queued at start, popped per new pair.
   int q1[$];
   int q3[$];

   task automatic fill(input int inst, input int nsweeps);
      if (inst == 1) q1.delete(); else q3.delete();
      for (int s = 0; s < nsweeps; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
               if (inst == 1) q1.push_back(a * 16 + b);
               else q3.push_back(a * 16 + b);
   endtask

   logic pv1 = 1'b0, pv3 = 1'b0;
   int   pp1, pp3, h1, h3, e1, e3;

   always @(negedge clk) begin
      if (busy1) begin
         if (!pv1 || int'({A1, B1}) != pp1) begin
            if (pv1) chk("hold1", h1, 2);
            e1 = (q1.size() != 0) ? q1.pop_front() : -1;
            chk("pair1", int'({A1, B1}), e1);
            h1 = 1;
         end else h1++;
      end else if (pv1 && done1) chk("hold1_last", h1, 2);
      pv1 = busy1;
      pp1 = int'({A1, B1});
   end

   always @(negedge clk) begin
      if (busy3) begin
         if (!pv3 || int'({A3, B3}) != pp3) begin
            if (pv3) chk("hold3", h3, 4);
            e3 = (q3.size() != 0) ? q3.pop_front() : -1;
            chk("pair3", int'({A3, B3}), e3);
            h3 = 1;
         end else h3++;
      end else if (pv3 && done3) chk("hold3_last", h3, 4);
      pv3 = busy3;
      pp3 = int'({A3, B3});
   end

   function automatic logic g_busy(input int i);
      return (i == 1) ? busy1 : busy3;
   endfunction
   function automatic logic g_done(input int i);
      return (i == 1) ? done1 : done3;
   endfunction
   function automatic logic g_pass(input int i);
      return (i == 1) ? pass1 : pass3;
   endfunction
   function automatic int g_err(input int i);
      return (i == 1) ? int'(err1) : int'(err3);
   endfunction

   task automatic set_start(input int i, input logic v);
      if (i == 1) start1 = v; else start3 = v;
   endtask

   // Pulse start and wait for done; reports busy cycles and done cycle index.
   task automatic sweep(input int inst, input int alat, input bit stuck,
                        output int nb, output int dcyc);
      if (inst == 1) begin alat1 = alat; stuck1 = stuck; end
      else begin alat3 = alat; stuck3 = stuck; end
      fill(inst, 1);
      @(negedge clk);
      set_start(inst, 1'b1);
      @(negedge clk);
      set_start(inst, 1'b0);
      nb   = 0;
      dcyc = 0;
      for (int c = 1; c <= 4000; c++) begin
         if (g_busy(inst)) nb++;
         if (g_done(inst)) begin
            dcyc = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   typedef struct {
      int inst;
      int alat;
      bit stuck;
      int exp_err;   // -1 means any nonzero count
      bit exp_pass;
      int fmode;     // 0 skip, 1 no capture, 2 capture expected
      int fa;
      int fb;
      int fz;
   } vec_t;

   vec_t tbl[5];
   int   nb, dcyc, ebusy, seen, ok, err_d, pass_d;

   initial begin
      rst = 1'b1;
      start1 = 1'b0; abort1 = 1'b0;
      start3 = 1'b0; abort3 = 1'b0;
      tbl[0] = '{1, 1, 1'b1, 120, 1'b0, 2, 1, 15, 0};
      tbl[1] = '{1, 2, 1'b0, -1,  1'b0, 0, 0, 0,  0};
      tbl[2] = '{1, 1, 1'b0, 0,   1'b1, 1, 0, 0,  0};
      tbl[3] = '{3, 3, 1'b0, 0,   1'b1, 1, 0, 0,  0};
      tbl[4] = '{3, 4, 1'b0, -1,  1'b0, 0, 0, 0,  0};

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_pass", int'(pass1), 0);
      chk("rst_err", int'(err1), 0);
      chk("rst_ab", int'({A1, B1}), 0);
      rst = 1'b0;
      @(negedge clk);

      foreach (tbl[k]) begin
         sweep(tbl[k].inst, tbl[k].alat, tbl[k].stuck, nb, dcyc);
         ebusy = 256 * ((tbl[k].inst == 1) ? 2 : 4);
         chk($sformatf("v%0d_busy_cycles", k), nb, ebusy);
         chk($sformatf("v%0d_done_cycle", k), dcyc, ebusy + 1);
         chk($sformatf("v%0d_pass", k), int'(g_pass(tbl[k].inst)),
             int'(tbl[k].exp_pass));
         if (tbl[k].exp_err < 0)
            chk($sformatf("v%0d_err_nonzero", k),
                int'(g_err(tbl[k].inst) != 0), 1);
         else
            chk($sformatf("v%0d_err", k), g_err(tbl[k].inst), tbl[k].exp_err);
`ifdef CADDER_SWEEP_FIRSTFAIL_EN
         if (tbl[k].fmode != 0) begin
            if (tbl[k].inst == 1)
               chk($sformatf("v%0d_fail_valid", k), int'(fv1), tbl[k].fmode - 1);
            else
               chk($sformatf("v%0d_fail_valid", k), int'(fv3), tbl[k].fmode - 1);
         end
         if (tbl[k].fmode == 2) begin
            chk($sformatf("v%0d_fail_a", k), int'(fa1), tbl[k].fa);
            chk($sformatf("v%0d_fail_b", k), int'(fb1), tbl[k].fb);
            chk($sformatf("v%0d_fail_z", k), int'(fz1), tbl[k].fz);
         end
`endif
         err_d  = g_err(tbl[k].inst);
         pass_d = int'(g_pass(tbl[k].inst));
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", k), int'(g_done(tbl[k].inst)), 0);
         chk($sformatf("v%0d_err_stable", k), g_err(tbl[k].inst), err_d);
         chk($sformatf("v%0d_pass_stable", k), int'(g_pass(tbl[k].inst)), pass_d);
      end
      alat1 = 1; stuck1 = 1'b0;
      alat3 = 3; stuck3 = 1'b0;

      // Abort on the 10th busy cycle after a passing sweep.
      fill(1, 1);
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      nb = 0;
      for (int c = 0; c < 100; c++) begin
         if (busy1) nb++;
         if (nb == 10) break;
         @(negedge clk);
      end
      chk("abort_reach10", nb, 10);
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      chk("abort_busy", int'(busy1), 0);
      chk("abort_done", int'(done1), 0);
      chk("abort_ab", int'({A1, B1}), 0);
      chk("abort_pass", int'(pass1), 0);
      seen = 0;
      repeat (600) begin
         @(negedge clk);
         if (done1 || busy1) seen++;
      end
      chk("abort_no_done", seen, 0);
      sweep(1, 1, 1'b0, nb, dcyc);
      chk("after_abort_done_cycle", dcyc, 513);
      chk("after_abort_pass", int'(pass1), 1);

      // start held high across a sweep.
      fill(1, 2);
      @(negedge clk); start1 = 1'b1;
      dcyc = 0;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         if (done1) begin
            dcyc = c;
            break;
         end
      end
      chk("held_done_cycle", dcyc, 513);
      @(negedge clk);
      chk("held_idle_gap", int'(busy1), 0);
      @(negedge clk);
      chk("held_restart", int'(busy1), 1);
      start1 = 1'b0;
      ok = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (done1) begin
            ok = 1;
            break;
         end
      end
      chk("held_second_done", ok, 1);
      chk("held_queue_empty", q1.size(), 0);
      chk("held_second_pass", int'(pass1), 1);

      // Reset mid-sweep once A reaches 5.
      fill(1, 1);
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      ok = 0;
      for (int c = 0; c < 1000; c++) begin
         if (busy1 && A1 == 4'd5) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("rst_mid_reach_a5", ok, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", int'(busy1), 0);
      chk("rst_mid_done", int'(done1), 0);
      chk("rst_mid_pass", int'(pass1), 0);
      chk("rst_mid_err", int'(err1), 0);
      chk("rst_mid_ab", int'({A1, B1}), 0);
`ifdef CADDER_SWEEP_FIRSTFAIL_EN
      chk("rst_mid_fail_valid", int'(fv1), 0);
`endif
      rst = 1'b0;
      seen = 0;
      repeat (700) begin
         @(negedge clk);
         if (done1 || busy1) seen++;
      end
      chk("rst_mid_no_done", seen, 0);
      q1.delete();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
